// File: rtl/ov5640_dvp_pkg.sv
// ---------------------------------------------------------------------------
// ov5640_dvp_pkg
// Shared definitions for the OV5640-style DVP transmitter:
//   - default DVP timing (pixels per line, blanking, vertical periods)
//   - FSM state enumeration used by the transmitter top level
//   - small constant helpers used to size counters
// ---------------------------------------------------------------------------
package ov5640_dvp_pkg;

  // Default VGA-like DVP timing
  localparam int DEF_H_ACTIVE    = 640;
  localparam int DEF_V_ACTIVE    = 480;
  localparam int DEF_H_BLANK     = 144;
  localparam int DEF_VSYNC_LINES = 4;
  localparam int DEF_V_BACK      = 16;
  localparam int DEF_V_FRONT     = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VSYNC  = 3'd1,
    ST_VBACK  = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_HBLANK = 3'd4,
    ST_VFRONT = 3'd5
  } dvp_state_e;

  // Bits needed for a counter running 0..count-1; at least one bit so a
  // single-value counter still has a legal vector width.
  function automatic int cnt_w(input int count);
    if (count <= 2) begin
      return 1;
    end else begin
      return $clog2(count);
    end
  endfunction

  function automatic int max_of(input int a, input int b);
    if (a > b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

endpackage

// File: rtl/ov5640_dvp_tx_if.sv
// ---------------------------------------------------------------------------
// ov5640_dvp_tx_if
// Upstream pixel stream into the DVP transmitter (valid/ready handshake).
//   pix_valid : source has a pixel on pix_data
//   pix_data  : RGB565 pixel
//   pix_ready : transmitter takes the pixel this cycle (valid && ready)
// Modports: master = pixel source, slave = transmitter.
// ---------------------------------------------------------------------------
interface ov5640_dvp_tx_if;
  logic        pix_valid;
  logic [15:0] pix_data;
  logic        pix_ready;

  modport master (
    output pix_valid,
    output pix_data,
    input  pix_ready
  );

  modport slave (
    input  pix_valid,
    input  pix_data,
    output pix_ready
  );
endinterface

// File: rtl/dvp_timing_cnt.sv
// ---------------------------------------------------------------------------
// dvp_timing_cnt
// Pixel-clock position within a line period plus a line counter.
//   cam_pclk, rst_n : clock, asynchronous active-low reset
//   en              : advance the pixel counter (held at 0 while idle)
//   line_clr        : restart the line count (end of a vertical phase)
//   pix_cnt         : cycle within the line period, 0..LINE_LEN-1
//   line_cnt        : line period within the current vertical phase
//   line_end        : strobe on the last cycle of a line period
// ---------------------------------------------------------------------------
module dvp_timing_cnt
  import ov5640_dvp_pkg::*;
#(
  parameter int LINE_LEN = 2 * DEF_H_ACTIVE + DEF_H_BLANK,
  parameter int LINE_MAX = DEF_V_ACTIVE,
  parameter int PIX_W    = cnt_w(LINE_LEN),
  parameter int LINE_W   = cnt_w(LINE_MAX)
) (
  input  logic              cam_pclk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              line_clr,
  output logic [PIX_W-1:0]  pix_cnt,
  output logic [LINE_W-1:0] line_cnt,
  output logic              line_end
);

  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(LINE_LEN - 1);

  logic [PIX_W-1:0]  pix_cnt_r;
  logic [LINE_W-1:0] line_cnt_r;
  logic              line_end_s;

  assign line_end_s = en && (pix_cnt_r == PIX_LAST);

  // Pixel counter wraps every line period; line counter steps on each wrap
  always_ff @(posedge cam_pclk or negedge rst_n) begin
    if (!rst_n) begin
      pix_cnt_r  <= {PIX_W{1'b0}};
      line_cnt_r <= {LINE_W{1'b0}};
    end else begin
      if (!en) begin
        pix_cnt_r <= pix_cnt_r;
      end else if (pix_cnt_r == PIX_LAST) begin
        pix_cnt_r <= {PIX_W{1'b0}};
      end else begin
        pix_cnt_r <= pix_cnt_r + PIX_W'(1);
      end

      if (line_clr) begin
        line_cnt_r <= {LINE_W{1'b0}};
      end else if (line_end_s) begin
        line_cnt_r <= line_cnt_r + LINE_W'(1);
      end else begin
        line_cnt_r <= line_cnt_r;
      end
    end
  end

  assign pix_cnt  = pix_cnt_r;
  assign line_cnt = line_cnt_r;
  assign line_end = line_end_s;

endmodule

// File: rtl/ov5640_dvp_tx.sv
// ---------------------------------------------------------------------------
// ov5640_dvp_tx
// Generates OV5640-style DVP frames (VSYNC / HREF / 8-bit data) from an
// RGB565 pixel stream. Each pixel is sent high byte first, then low byte.
//   cam_pclk, rst_n : clock, asynchronous active-low reset
//   tx_en           : level; frames are produced while high (a frame in
//                     progress always completes)
//   pix             : pixel stream slave (pix_valid/pix_data/pix_ready)
//   cam_vsync       : high for VSYNC_LINES line periods at frame start
//   cam_href        : high for the 2*H_ACTIVE byte cycles of each line
//   cam_data        : DVP byte, 0 whenever cam_href is low
//   underrun        : sticky; a pixel was missing when it was needed
//   frame_cnt       : completed frames, wraps 0xFFFF -> 0
// Timing parameters must all be >= 1 and H_BLANK >= 2.
// ---------------------------------------------------------------------------
module ov5640_dvp_tx
  import ov5640_dvp_pkg::*;
#(
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int H_BLANK     = DEF_H_BLANK,
  parameter int VSYNC_LINES = DEF_VSYNC_LINES,
  parameter int V_BACK      = DEF_V_BACK,
  parameter int V_FRONT     = DEF_V_FRONT
) (
  input  logic                cam_pclk,
  input  logic                rst_n,
  input  logic                tx_en,
  ov5640_dvp_tx_if.slave      pix,
  output logic                cam_vsync,
  output logic                cam_href,
  output logic [7:0]          cam_data,
  output logic                underrun,
  output logic [15:0]         frame_cnt
);

  localparam int LINE_LEN = 2 * H_ACTIVE + H_BLANK;
  localparam int LINE_MAX = max_of(max_of(VSYNC_LINES, V_BACK), max_of(V_ACTIVE, V_FRONT));
  localparam int PIX_W    = cnt_w(LINE_LEN);
  localparam int LINE_W   = cnt_w(LINE_MAX);

  localparam logic [PIX_W-1:0]  PIX_PRE  = PIX_W'(LINE_LEN - 2);
  localparam logic [PIX_W-1:0]  ACT_LAST = PIX_W'(2 * H_ACTIVE - 1);
  localparam logic [PIX_W-1:0]  ACT_PRE  = PIX_W'(2 * H_ACTIVE - 2);
  localparam logic [LINE_W-1:0] VS_LAST  = LINE_W'(VSYNC_LINES - 1);
  localparam logic [LINE_W-1:0] VB_LAST  = LINE_W'(V_BACK - 1);
  localparam logic [LINE_W-1:0] VA_LAST  = LINE_W'(V_ACTIVE - 1);
  localparam logic [LINE_W-1:0] VF_LAST  = LINE_W'(V_FRONT - 1);

  dvp_state_e        state_r;
  dvp_state_e        nxt_state_s;
  logic              line_clr_s;
  logic              frame_done_s;
  logic              ready_nxt_s;
  logic [7:0]        data_nxt_s;
  logic [7:0]        low_nxt_s;
  logic              underrun_nxt_s;

  logic [PIX_W-1:0]  pix_cnt_s;
  logic [LINE_W-1:0] line_cnt_s;
  logic              line_end_s;
  logic              cnt_en_s;

  logic              cam_vsync_r;
  logic              cam_href_r;
  logic [7:0]        cam_data_r;
  logic [7:0]        low_r;
  logic              pix_ready_r;
  logic              underrun_r;
  logic [15:0]       frame_cnt_r;

  assign cnt_en_s = (state_r != ST_IDLE);

  dvp_timing_cnt #(
    .LINE_LEN (LINE_LEN),
    .LINE_MAX (LINE_MAX),
    .PIX_W    (PIX_W),
    .LINE_W   (LINE_W)
  ) u_timing (
    .cam_pclk (cam_pclk),
    .rst_n    (rst_n),
    .en       (cnt_en_s),
    .line_clr (line_clr_s),
    .pix_cnt  (pix_cnt_s),
    .line_cnt (line_cnt_s),
    .line_end (line_end_s)
  );

  // FSM state register
  always_ff @(posedge cam_pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= nxt_state_s;
    end
  end

  // FSM next state; line_clr restarts the line count at each phase change
  always_comb begin
    nxt_state_s  = state_r;
    line_clr_s   = 1'b0;
    frame_done_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (tx_en) begin
          nxt_state_s = ST_VSYNC;
        end else begin
          nxt_state_s = ST_IDLE;
        end
      end
      ST_VSYNC: begin
        if (line_end_s && (line_cnt_s == VS_LAST)) begin
          nxt_state_s = ST_VBACK;
          line_clr_s  = 1'b1;
        end else begin
          nxt_state_s = ST_VSYNC;
        end
      end
      ST_VBACK: begin
        if (line_end_s && (line_cnt_s == VB_LAST)) begin
          nxt_state_s = ST_ACTIVE;
          line_clr_s  = 1'b1;
        end else begin
          nxt_state_s = ST_VBACK;
        end
      end
      ST_ACTIVE: begin
        if (pix_cnt_s == ACT_LAST) begin
          nxt_state_s = ST_HBLANK;
        end else begin
          nxt_state_s = ST_ACTIVE;
        end
      end
      ST_HBLANK: begin
        if (line_end_s && (line_cnt_s == VA_LAST)) begin
          nxt_state_s = ST_VFRONT;
          line_clr_s  = 1'b1;
        end else if (line_end_s) begin
          nxt_state_s = ST_ACTIVE;
        end else begin
          nxt_state_s = ST_HBLANK;
        end
      end
      ST_VFRONT: begin
        if (line_end_s && (line_cnt_s == VF_LAST)) begin
          line_clr_s   = 1'b1;
          frame_done_s = 1'b1;
          if (tx_en) begin
            nxt_state_s = ST_VSYNC;
          end else begin
            nxt_state_s = ST_IDLE;
          end
        end else begin
          nxt_state_s = ST_VFRONT;
        end
      end
      default: begin
        nxt_state_s = ST_IDLE;
        line_clr_s  = 1'b1;
      end
    endcase
  end

  // pix_ready is registered, so it is decided two cycles ahead of the high
  // byte: the current cycle is two before a high-byte slot when the next
  // even ACTIVE column follows, or we sit at LINE_LEN-2 just before a line
  // starts (last VBACK line, or HBLANK of any line but the last).
  always_comb begin
    ready_nxt_s = 1'b0;
    case (state_r)
      ST_ACTIVE: ready_nxt_s = ~pix_cnt_s[0] && (pix_cnt_s != ACT_PRE);
      ST_HBLANK: ready_nxt_s = (pix_cnt_s == PIX_PRE) && (line_cnt_s != VA_LAST);
      ST_VBACK:  ready_nxt_s = (pix_cnt_s == PIX_PRE) && (line_cnt_s == VB_LAST);
      default:   ready_nxt_s = 1'b0;
    endcase
  end

  // Byte serializer: a pixel taken while pix_ready is high goes out as the
  // high byte next cycle, its low byte is parked in low_r for the cycle
  // after. A missing pixel is replaced by zero and flagged.
  always_comb begin
    data_nxt_s     = 8'h00;
    low_nxt_s      = low_r;
    underrun_nxt_s = underrun_r;
    if (pix_ready_r) begin
      if (pix.pix_valid) begin
        data_nxt_s = pix.pix_data[15:8];
        low_nxt_s  = pix.pix_data[7:0];
      end else begin
        data_nxt_s     = 8'h00;
        low_nxt_s      = 8'h00;
        underrun_nxt_s = 1'b1;
      end
    end else if (nxt_state_s == ST_ACTIVE) begin
      data_nxt_s = low_r;
    end else begin
      data_nxt_s = 8'h00;
    end
  end

  // Output and datapath registers; outputs follow the state they belong to
  always_ff @(posedge cam_pclk or negedge rst_n) begin
    if (!rst_n) begin
      cam_vsync_r <= 1'b0;
      cam_href_r  <= 1'b0;
      cam_data_r  <= 8'h00;
      low_r       <= 8'h00;
      pix_ready_r <= 1'b0;
      underrun_r  <= 1'b0;
      frame_cnt_r <= 16'h0000;
    end else begin
      cam_vsync_r <= (nxt_state_s == ST_VSYNC);
      cam_href_r  <= (nxt_state_s == ST_ACTIVE);
      cam_data_r  <= data_nxt_s;
      low_r       <= low_nxt_s;
      pix_ready_r <= ready_nxt_s;
      underrun_r  <= underrun_nxt_s;
      if (frame_done_s) begin
        frame_cnt_r <= frame_cnt_r + 16'd1;
      end else begin
        frame_cnt_r <= frame_cnt_r;
      end
    end
  end

  assign cam_vsync     = cam_vsync_r;
  assign cam_href      = cam_href_r;
  assign cam_data      = cam_data_r;
  assign pix.pix_ready = pix_ready_r;
  assign underrun      = underrun_r;
  assign frame_cnt     = frame_cnt_r;

endmodule
